vga_sync_gen: RTL and testbench

- Raster timing generator that drives the pixel-colour stage's VIDON, HC and VC inputs and the monitor's HSYNC and VSYNC lines.
- Default mode is 640x480 at 60 Hz, with a 25 MHz pixel rate derived from the 50 MHz board clock through a clock-enable divider. No derived clocks are used.
- Also supplies a pixel-enable strobe and a frame-start pulse, so that downstream pixel sources stay in lockstep with the counters.

---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/vga_pix_ce.sv | 35 +++
 rtl/vga_sync_gen.sv | 116 +++++++++++
 tb/tb_vga_sync_gen.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and coordinate type for the VGA pipeline.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  // Default 640x480 @ 60 Hz timing with a 25 MHz pixel rate from 50 MHz.
  localparam int unsigned DEF_PIX_DIV = 2;
  localparam int unsigned DEF_H_VIS   = 640;
  localparam int unsigned DEF_H_FP    = 16;
  localparam int unsigned DEF_H_SYNC  = 96;
  localparam int unsigned DEF_H_BP    = 48;
  localparam int unsigned DEF_V_VIS   = 480;
  localparam int unsigned DEF_V_FP    = 10;
  localparam int unsigned DEF_V_SYNC  = 2;
  localparam int unsigned DEF_V_BP    = 33;

  localparam int unsigned H_TOTAL = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int unsigned H_SYNC_START = DEF_H_VIS + DEF_H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
  localparam int unsigned V_SYNC_START = DEF_V_VIS + DEF_V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

  // Half-open range test lo <= v < hi on a coordinate.
  function automatic logic in_range(coord_t v, int unsigned lo, int unsigned hi);
    return (32'(v) >= lo) && (32'(v) < hi);
  endfunction

endpackage

// File: rtl/vga_pix_ce.sv
// Clock-enable divider: one-clock PIX_CE strobe every PIX_DIV system clocks.
module vga_pix_ce #(
  parameter int unsigned PIX_DIV = 2
) (
  input  logic CLK,
  input  logic RST,
  output logic PIX_CE
);

  localparam int unsigned DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [DIV_W-1:0] w_div_nxt;
  logic             r_pix_ce;

  // Wrapping divider count.
  always_comb begin
    w_div_nxt = (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
  end

  // Strobe is registered from the next count so it is high while the count sits at its last value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_div_cnt <= '0;
      r_pix_ce  <= (PIX_DIV == 1);
    end else begin
      r_div_cnt <= w_div_nxt;
      r_pix_ce  <= (w_div_nxt == DIV_LAST);
    end
  end

  assign PIX_CE = r_pix_ce;

endmodule

// File: rtl/vga_sync_gen.sv
// Raster counters plus registered sync/visible decode and frame-start pulse.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned PIX_DIV  = DEF_PIX_DIV,
  parameter int unsigned H_VIS    = DEF_H_VIS,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_VIS    = DEF_V_VIS,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic   CLK,
  input  logic   RST,
  output coord_t HC,
  output coord_t VC,
  output logic   VIDON,
  output logic   HSYNC,
  output logic   VSYNC,
  output logic   PIX_CE,
  output logic   FRAME_START
);

  localparam int unsigned H_TOT   = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT   = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_LO   = H_VIS + H_FP;
  localparam int unsigned HS_HI   = HS_LO + H_SYNC;
  localparam int unsigned VS_LO   = V_VIS + V_FP;
  localparam int unsigned VS_HI   = VS_LO + V_SYNC;
  localparam coord_t      H_LAST  = coord_t'(H_TOT - 1);
  localparam coord_t      V_LAST  = coord_t'(V_TOT - 1);
  localparam logic        SYNC_ON = SYNC_POL;

  // Coordinates must fit the 10-bit counters and the divider must be non-zero.
  if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_total
    $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed 1024");
  end
  if (PIX_DIV < 1) begin : g_bad_div
    $error("vga_sync_gen: PIX_DIV must be at least 1");
  end

  logic   w_pix_ce;
  coord_t r_hc;
  coord_t r_vc;
  coord_t w_hc_nxt;
  coord_t w_vc_nxt;
  logic   w_vidon_nxt;
  logic   w_hs_on_nxt;
  logic   w_vs_on_nxt;
  logic   w_frame_nxt;
  logic   r_vidon;
  logic   r_hsync;
  logic   r_vsync;
  logic   r_frame_start;

  vga_pix_ce #(
    .PIX_DIV (PIX_DIV)
  ) u_pix_ce (
    .CLK    (CLK),
    .RST    (RST),
    .PIX_CE (w_pix_ce)
  );

  // Next raster position: advance on pixel ticks, line and frame wrap in one update.
  always_comb begin
    w_hc_nxt = r_hc;
    w_vc_nxt = r_vc;
    if (w_pix_ce) begin
      if (r_hc == H_LAST) begin
        w_hc_nxt = '0;
        w_vc_nxt = (r_vc == V_LAST) ? '0 : r_vc + 1'b1;
      end else begin
        w_hc_nxt = r_hc + 1'b1;
      end
    end
  end

  // Decode from the next position so registered outputs line up with the counters.
  always_comb begin
    w_vidon_nxt = in_range(w_hc_nxt, 0, H_VIS) && in_range(w_vc_nxt, 0, V_VIS);
    w_hs_on_nxt = in_range(w_hc_nxt, HS_LO, HS_HI);
    w_vs_on_nxt = in_range(w_vc_nxt, VS_LO, VS_HI);
    w_frame_nxt = w_pix_ce && (w_hc_nxt == '0) && (w_vc_nxt == '0);
  end

  // Counter and decode registers; reset parks the raster at the last back-porch position.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hc          <= H_LAST;
      r_vc          <= V_LAST;
      r_vidon       <= 1'b0;
      r_hsync       <= ~SYNC_ON;
      r_vsync       <= ~SYNC_ON;
      r_frame_start <= 1'b0;
    end else begin
      r_hc          <= w_hc_nxt;
      r_vc          <= w_vc_nxt;
      r_vidon       <= w_vidon_nxt;
      r_hsync       <= w_hs_on_nxt ? SYNC_ON : ~SYNC_ON;
      r_vsync       <= w_vs_on_nxt ? SYNC_ON : ~SYNC_ON;
      r_frame_start <= w_frame_nxt;
    end
  end

  assign HC          = r_hc;
  assign VC          = r_vc;
  assign VIDON       = r_vidon;
  assign HSYNC       = r_hsync;
  assign VSYNC       = r_vsync;
  assign PIX_CE      = w_pix_ce;
  assign FRAME_START = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default-timing line check, table-driven vectors on a reduced raster, and scoreboard over frames.
module tb_vga_sync_gen;

  // Reduced raster: 16 x 12 positions, HSYNC at HC 10..12, VSYNC at VC 8..9.
  localparam int HV = 8, HFP = 2, HSW = 3, HBP = 3;
  localparam int VV = 6, VFP = 2, VSW = 2, VBP = 2;
  localparam int HT = HV + HFP + HSW + HBP;
  localparam int VT = VV + VFP + VSW + VBP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_d = 1'b1;

  logic [9:0] hc, vc, hc1, vc1, hcd, vcd;
  logic vid, hs, vs, ce, fs;
  logic vid1, hs1, vs1, ce1, fs1;
  logic vidd, hsd, vsd, ced, fsd;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vga_sync_gen #(
    .PIX_DIV(2), .H_VIS(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_VIS(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .SYNC_POL(1'b0)
  ) u_dut (
    .CLK(clk), .RST(rst), .HC(hc), .VC(vc), .VIDON(vid), .HSYNC(hs),
    .VSYNC(vs), .PIX_CE(ce), .FRAME_START(fs)
  );

  vga_sync_gen #(
    .PIX_DIV(1), .H_VIS(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_VIS(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .SYNC_POL(1'b0)
  ) u_dut1 (
    .CLK(clk), .RST(rst), .HC(hc1), .VC(vc1), .VIDON(vid1), .HSYNC(hs1),
    .VSYNC(vs1), .PIX_CE(ce1), .FRAME_START(fs1)
  );

  vga_sync_gen u_def (
    .CLK(clk), .RST(rst_d), .HC(hcd), .VC(vcd), .VIDON(vidd), .HSYNC(hsd),
    .VSYNC(vsd), .PIX_CE(ced), .FRAME_START(fsd)
  );

  typedef struct {
    bit rst;
    int clocks;
    int hc;
    int vc;
    bit vid;
    bit hs;
    bit vs;
    bit ce;
    bit fs;
  } vec_t;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Independent model of one sampled cycle of the reduced raster; returns number of disagreements.
  function automatic int sb_one(int h, int v, int ph, int pv, bit pce,
                                bit dvid, bit dhs, bit dvs, bit dfs);
    int eh, ev, e;
    eh = ph;
    ev = pv;
    if (pce) begin
      if (ph == HT - 1) begin
        eh = 0;
        ev = (pv == VT - 1) ? 0 : pv + 1;
      end else begin
        eh = ph + 1;
      end
    end
    e = 0;
    if (h != eh) e++;
    if (v != ev) e++;
    if (dvid != ((h < HV) && (v < VV))) e++;
    if (dhs != !((h >= HV + HFP) && (h < HV + HFP + HSW))) e++;
    if (dvs != !((v >= VV + VFP) && (v < VV + VFP + VSW))) e++;
    if (dfs != (pce && h == 0 && v == 0)) e++;
    return e;
  endfunction

  initial begin
    vec_t vecs[$];
    int n_vid, n_hs, hs_first, hs_last, hc_err;
    int sb0, sb1, ce_err;
    int fs0_t[$];
    int fs1_t[$];
    int ph0, pv0, ph1, pv1;
    bit pce0, pce1;

    // ---------------- default 640x480 timing: reset and one line ----------------
    rst_d = 1'b1;
    rst   = 1'b1;
    step(3);
    check("def.rst.hc", int'(hcd), 799);
    check("def.rst.vc", int'(vcd), 524);
    check("def.rst.vidon", int'(vidd), 0);
    check("def.rst.hsync", int'(hsd), 1);
    check("def.rst.vsync", int'(vsd), 1);
    check("def.rst.fs", int'(fsd), 0);
    check("def.rst.ce", int'(ced), 0);
    rst_d = 1'b0;
    step(1);
    check("def.rel1.ce", int'(ced), 1);
    check("def.rel1.hc", int'(hcd), 799);
    step(1);
    check("def.rel2.hc", int'(hcd), 0);
    check("def.rel2.vc", int'(vcd), 0);
    check("def.rel2.vidon", int'(vidd), 1);
    check("def.rel2.fs", int'(fsd), 1);
    n_vid = 0; n_hs = 0; hs_first = -1; hs_last = -1; hc_err = 0;
    for (int k = 0; k < 800; k++) begin
      if (int'(hcd) != k || vcd != 10'd0) hc_err++;
      if (vidd) n_vid++;
      if (!hsd) begin
        n_hs++;
        if (hs_first < 0) hs_first = k;
        hs_last = k;
      end
      step(2);
    end
    check("def.line.pos", hc_err, 0);
    check("def.line.vidon_ticks", n_vid, 640);
    check("def.line.hsync_ticks", n_hs, 96);
    check("def.line.hsync_first", hs_first, 656);
    check("def.line.hsync_last", hs_last, 751);
    check("def.wrap.hc", int'(hcd), 0);
    check("def.wrap.vc", int'(vcd), 1);

    // ---------------- reduced raster, PIX_DIV=2: directed vectors ----------------
    //                rst clk  hc  vc vid hs vs ce fs
    vecs.push_back('{1'b1,   3, 15, 11, 0, 1, 1, 0, 0});
    vecs.push_back('{1'b0,   1, 15, 11, 0, 1, 1, 1, 0});
    vecs.push_back('{1'b0,   1,  0,  0, 1, 1, 1, 0, 1});
    vecs.push_back('{1'b0,   1,  0,  0, 1, 1, 1, 1, 0});
    vecs.push_back('{1'b0,   1,  1,  0, 1, 1, 1, 0, 0});
    vecs.push_back('{1'b0,  12,  7,  0, 1, 1, 1, 0, 0});
    vecs.push_back('{1'b0,   2,  8,  0, 0, 1, 1, 0, 0});
    vecs.push_back('{1'b0,   4, 10,  0, 0, 0, 1, 0, 0});
    vecs.push_back('{1'b0,   4, 12,  0, 0, 0, 1, 0, 0});
    vecs.push_back('{1'b0,   2, 13,  0, 0, 1, 1, 0, 0});
    vecs.push_back('{1'b0,   4, 15,  0, 0, 1, 1, 0, 0});
    vecs.push_back('{1'b0,   2,  0,  1, 1, 1, 1, 0, 0});
    vecs.push_back('{1'b0, 224,  0,  8, 0, 1, 0, 0, 0});
    vecs.push_back('{1'b0,  54, 11,  9, 0, 0, 0, 0, 0});
    vecs.push_back('{1'b0,  10,  0, 10, 0, 1, 1, 0, 0});
    vecs.push_back('{1'b0,  62, 15, 11, 0, 1, 1, 0, 0});
    vecs.push_back('{1'b0,   2,  0,  0, 1, 1, 1, 0, 1});
    vecs.push_back('{1'b0,   1,  0,  0, 1, 1, 1, 1, 0});
    vecs.push_back('{1'b0,   1,  1,  0, 1, 1, 1, 0, 0});
    vecs.push_back('{1'b0, 276, 11,  8, 0, 0, 0, 0, 0});
    vecs.push_back('{1'b1,   1, 15, 11, 0, 1, 1, 0, 0});
    vecs.push_back('{1'b0,   2,  0,  0, 1, 1, 1, 0, 1});
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      step(vecs[i].clocks);
      check($sformatf("v%0d.hc", i), int'(hc), vecs[i].hc);
      check($sformatf("v%0d.vc", i), int'(vc), vecs[i].vc);
      check($sformatf("v%0d.vidon", i), int'(vid), int'(vecs[i].vid));
      check($sformatf("v%0d.hsync", i), int'(hs), int'(vecs[i].hs));
      check($sformatf("v%0d.vsync", i), int'(vs), int'(vecs[i].vs));
      check($sformatf("v%0d.pix_ce", i), int'(ce), int'(vecs[i].ce));
      check($sformatf("v%0d.frame_start", i), int'(fs), int'(vecs[i].fs));
    end

    // ---------------- PIX_DIV=1 reset and first tick ----------------
    rst = 1'b1;
    step(2);
    check("d1.rst.hc", int'(hc1), 15);
    check("d1.rst.vc", int'(vc1), 11);
    check("d1.rst.ce", int'(ce1), 1);
    check("d1.rst.hsync", int'(hs1), 1);
    check("d1.rst.vsync", int'(vs1), 1);
    check("d1.rst.fs", int'(fs1), 0);
    rst = 1'b0;
    step(1);
    check("d1.rel1.hc", int'(hc1), 0);
    check("d1.rel1.vc", int'(vc1), 0);
    check("d1.rel1.fs", int'(fs1), 1);
    check("d1.rel1.vidon", int'(vid1), 1);

    // ---------------- scoreboard and frame period over three frames ----------------
    fs1_t.push_back(1);
    ph0 = int'(hc);  pv0 = int'(vc);  pce0 = ce;
    ph1 = int'(hc1); pv1 = int'(vc1); pce1 = ce1;
    sb0 = 0; sb1 = 0; ce_err = 0;
    for (int c = 2; c <= 1200; c++) begin
      step(1);
      sb0 += sb_one(int'(hc), int'(vc), ph0, pv0, pce0, vid, hs, vs, fs);
      sb1 += sb_one(int'(hc1), int'(vc1), ph1, pv1, pce1, vid1, hs1, vs1, fs1);
      if (ce == pce0) ce_err++;
      if (!ce1) ce_err++;
      if (fs)  fs0_t.push_back(c);
      if (fs1) fs1_t.push_back(c);
      ph0 = int'(hc);  pv0 = int'(vc);  pce0 = ce;
      ph1 = int'(hc1); pv1 = int'(vc1); pce1 = ce1;
    end
    check("sb.div2", sb0, 0);
    check("sb.div1", sb1, 0);
    check("sb.pix_ce", ce_err, 0);
    check("fs.div2.count", fs0_t.size(), 4);
    check("fs.div1.count", fs1_t.size(), 7);
    if (fs0_t.size() >= 3) begin
      check("fs.div2.first", fs0_t[0], 2);
      check("fs.div2.period0", fs0_t[1] - fs0_t[0], 2 * HT * VT);
      check("fs.div2.period1", fs0_t[2] - fs0_t[1], 2 * HT * VT);
    end else begin
      check("fs.div2.seen", fs0_t.size(), 3);
    end
    if (fs1_t.size() >= 3) begin
      check("fs.div1.period0", fs1_t[1] - fs1_t[0], HT * VT);
      check("fs.div1.period1", fs1_t[2] - fs1_t[1], HT * VT);
    end else begin
      check("fs.div1.seen", fs1_t.size(), 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
